// File: rtl/iluminacao_multizona.sv
// N-zone automatic/manual lighting controller: per-zone button classifier, lamp FSM and shutdown timer.
// Optional macro AUTO_DIM_EN adds a blinking shutdown warning on saida near the end of the countdown.
module iluminacao_multizona #(
  parameter int N_ZONES           = 4,
  parameter int DEBOUNCE_P        = 300,
  parameter int SWITCH_MODE_MIN_T = 5000,
  parameter int AUTO_SHUTDOWN_T   = 30000,
  parameter int CNT_W             = 16,
  parameter int WARN_T            = 5000,
  parameter int PWM_W             = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_ZONES-1:0] infravermelho,
  input  logic [N_ZONES-1:0] push_button,
  input  logic               desliga_tudo,
  output logic [N_ZONES-1:0] saida,
  output logic [N_ZONES-1:0] led
);

  typedef enum logic [1:0] {IDLE = 2'd0, DEB = 2'd1, HELD = 2'd2, REL = 2'd3} btn_state_t;
  typedef enum logic [1:0] {DESL_AUT = 2'd0, LIG_AUT = 2'd1, DESL_MAN = 2'd2, LIG_MAN = 2'd3} lamp_state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_P - 1);
  localparam logic [CNT_W-1:0] LONG_MIN = CNT_W'(SWITCH_MODE_MIN_T);
  localparam logic [CNT_W-1:0] TMR_LAST = CNT_W'(AUTO_SHUTDOWN_T - 1);

  if ((64'(AUTO_SHUTDOWN_T) >= (64'd1 << CNT_W)) || (64'(SWITCH_MODE_MIN_T) >= (64'd1 << CNT_W)) ||
      (DEBOUNCE_P < 32'sd2) || (WARN_T > AUTO_SHUTDOWN_T) || (PWM_W < 32'sd1)) begin : g_param_check
    $error("iluminacao_multizona: CNT_W too narrow or timing parameters out of range");
  end

  logic [N_ZONES-1:0] ir_meta_r, ir_sync_r, btn_meta_r, btn_sync_r;

  // Two-flop synchronizers for the asynchronous per-zone inputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      ir_meta_r  <= {N_ZONES{1'b0}};
      ir_sync_r  <= {N_ZONES{1'b0}};
      btn_meta_r <= {N_ZONES{1'b0}};
      btn_sync_r <= {N_ZONES{1'b0}};
    end else begin
      ir_meta_r  <= infravermelho;
      ir_sync_r  <= ir_meta_r;
      btn_meta_r <= push_button;
      btn_sync_r <= btn_meta_r;
    end
  end

`ifdef AUTO_DIM_EN
  logic [PWM_W-1:0] pwm_r;

  // Shared free-running counter; its MSB is the warning blink
  always_ff @(posedge clk) begin
    if (!rst) begin
      pwm_r <= {PWM_W{1'b0}};
    end else begin
      pwm_r <= pwm_r + PWM_W'(1);
    end
  end
`endif

  for (genvar z = 0; z < N_ZONES; z++) begin : g_zone
    btn_state_t       btn_st_r, btn_st_s;
    lamp_state_t      lamp_st_r, lamp_st_s;
    logic [CNT_W-1:0] btn_cnt_r, btn_cnt_s, tmr_r, tmr_s;
    logic             long_r, long_s;
    logic             btn_s, pres_s, curto_s, longo_s, timeout_s;

    assign btn_s     = btn_sync_r[z];
    assign pres_s    = ir_sync_r[z];
    assign curto_s   = (btn_st_r == REL) && !long_r;
    assign longo_s   = (btn_st_r == REL) && long_r;
    assign timeout_s = (lamp_st_r == LIG_AUT) && !pres_s && (tmr_r == TMR_LAST);

    // Zone state registers
    always_ff @(posedge clk) begin
      if (!rst) begin
        btn_st_r  <= IDLE;
        btn_cnt_r <= CNT_ZERO;
        long_r    <= 1'b0;
        lamp_st_r <= DESL_AUT;
        tmr_r     <= CNT_ZERO;
      end else begin
        btn_st_r  <= btn_st_s;
        btn_cnt_r <= btn_cnt_s;
        long_r    <= long_s;
        lamp_st_r <= lamp_st_s;
        tmr_r     <= tmr_s;
      end
    end

    // Button classifier: counter holds the number of synced-high cycles seen so far
    always_comb begin
      btn_st_s  = btn_st_r;
      btn_cnt_s = btn_cnt_r;
      long_s    = long_r;
      case (btn_st_r)
        IDLE: begin
          if (btn_s) begin
            btn_st_s  = DEB;
            btn_cnt_s = CNT_ONE;
          end else begin
            btn_cnt_s = CNT_ZERO;
          end
        end
        DEB: begin
          if (!btn_s) begin
            btn_st_s  = IDLE;
            btn_cnt_s = CNT_ZERO;
          end else if (btn_cnt_r == DEB_LAST) begin
            btn_st_s  = HELD;
            btn_cnt_s = btn_cnt_r + CNT_ONE;
          end else begin
            btn_cnt_s = btn_cnt_r + CNT_ONE;
          end
        end
        HELD: begin
          if (!btn_s) begin
            btn_st_s = REL;
            long_s   = (btn_cnt_r >= LONG_MIN);
          end else if (btn_cnt_r != CNT_MAX) begin
            btn_cnt_s = btn_cnt_r + CNT_ONE;
          end else begin
            btn_cnt_s = btn_cnt_r;
          end
        end
        REL: begin
          btn_st_s  = IDLE;
          btn_cnt_s = CNT_ZERO;
          long_s    = 1'b0;
        end
        default: begin
          btn_st_s  = IDLE;
          btn_cnt_s = CNT_ZERO;
          long_s    = 1'b0;
        end
      endcase
    end

    // Lamp FSM: all-off beats long press, which beats every other event
    always_comb begin
      lamp_st_s = lamp_st_r;
      if (desliga_tudo) begin
        lamp_st_s = DESL_AUT;
      end else if (longo_s) begin
        lamp_st_s = ((lamp_st_r == DESL_MAN) || (lamp_st_r == LIG_MAN)) ? DESL_AUT : DESL_MAN;
      end else begin
        case (lamp_st_r)
          DESL_AUT: lamp_st_s = pres_s    ? LIG_AUT  : DESL_AUT;
          LIG_AUT:  lamp_st_s = timeout_s ? DESL_AUT : LIG_AUT;
          DESL_MAN: lamp_st_s = curto_s   ? LIG_MAN  : DESL_MAN;
          LIG_MAN:  lamp_st_s = curto_s   ? DESL_MAN : LIG_MAN;
          default:  lamp_st_s = DESL_AUT;
        endcase
      end
    end

    // Shutdown timer only runs while staying in LIG_AUT without presence
    always_comb begin
      if ((lamp_st_r == LIG_AUT) && (lamp_st_s == LIG_AUT) && !pres_s) begin
        tmr_s = tmr_r + CNT_ONE;
      end else begin
        tmr_s = CNT_ZERO;
      end
    end

    assign led[z] = (lamp_st_r == DESL_MAN) || (lamp_st_r == LIG_MAN);
`ifdef AUTO_DIM_EN
    localparam logic [CNT_W-1:0] WARN_START = CNT_W'(AUTO_SHUTDOWN_T - WARN_T);
    assign saida[z] = (lamp_st_r == LIG_MAN) ||
                      ((lamp_st_r == LIG_AUT) && ((tmr_r < WARN_START) || pwm_r[PWM_W-1]));
`else
    assign saida[z] = (lamp_st_r == LIG_AUT) || (lamp_st_r == LIG_MAN);
`endif
  end

endmodule

// File: tb/tb_iluminacao_multizona.sv
// Self-checking bench for iluminacao_multizona: button table, hand-written corner sequences
// and randomized traffic against a timestamp-based reference model (AUTO_DIM_EN aware).
module tb_iluminacao_multizona;
  localparam int NZ = 2;
  localparam int P  = 4;
  localparam int S  = 20;
  localparam int T  = 50;
  localparam int W  = 10;
  localparam int PW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          desliga_tudo = 1'b0;
  logic [NZ-1:0] infravermelho = '0;
  logic [NZ-1:0] push_button = '0;
  logic [NZ-1:0] saida, led;

  int n_tests = 0;
  int n_fail  = 0;

  iluminacao_multizona #(
    .N_ZONES(NZ), .DEBOUNCE_P(P), .SWITCH_MODE_MIN_T(S), .AUTO_SHUTDOWN_T(T),
    .CNT_W(16), .WARN_T(W), .PWM_W(PW)
  ) dut (
    .clk(clk), .rst(rst), .infravermelho(infravermelho), .push_button(push_button),
    .desliga_tudo(desliga_tudo), .saida(saida), .led(led)
  );

  always #5 clk = ~clk;

  // Reference model: raw inputs delayed two cycles, run length of synced-high button,
  // pending event (0 none, 1 short, 2 long), mode bits and time of last presence.
  logic [NZ-1:0] m_ir_d1 = '0, m_ir_d2 = '0, m_bt_d1 = '0, m_bt_d2 = '0;
  int     m_run    [NZ];
  int     m_ev     [NZ];
  bit     m_manual [NZ];
  bit     m_on     [NZ];
  longint m_last   [NZ];
  longint m_now = 0;
  int     m_pwm = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, m_now, act, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic [NZ-1:0] ir, input logic [NZ-1:0] bt, input logic dt);
    m_now++;
    if (!r) begin
      m_ir_d1 = '0; m_ir_d2 = '0; m_bt_d1 = '0; m_bt_d2 = '0; m_pwm = 0;
      for (int z = 0; z < NZ; z++) begin
        m_run[z] = 0; m_ev[z] = 0; m_manual[z] = 1'b0; m_on[z] = 1'b0; m_last[z] = 0;
      end
    end else begin
      for (int z = 0; z < NZ; z++) begin
        int ev;
        ev = m_ev[z];
        if (m_bt_d2[z]) begin
          m_run[z]++;
          m_ev[z] = 0;
        end else begin
          m_ev[z]  = (m_run[z] < P) ? 0 : ((m_run[z] >= S) ? 2 : 1);
          m_run[z] = 0;
        end
        if (dt) begin
          m_manual[z] = 1'b0; m_on[z] = 1'b0;
        end else if (ev == 2) begin
          m_manual[z] = !m_manual[z]; m_on[z] = 1'b0;
        end else if (m_manual[z]) begin
          if (ev == 1) m_on[z] = !m_on[z];
        end else if (m_ir_d2[z]) begin
          m_on[z] = 1'b1; m_last[z] = m_now;
        end else if (m_on[z] && (m_now - m_last[z] >= longint'(T))) begin
          m_on[z] = 1'b0;
        end
      end
      m_ir_d2 = m_ir_d1; m_ir_d1 = ir;
      m_bt_d2 = m_bt_d1; m_bt_d1 = bt;
      m_pwm++;
    end
  endtask

  function automatic logic [NZ-1:0] exp_saida();
    logic [NZ-1:0] s;
    for (int z = 0; z < NZ; z++) begin
      s[z] = m_on[z];
`ifdef AUTO_DIM_EN
      if (m_on[z] && !m_manual[z] && ((m_now - m_last[z]) >= longint'(T - W)))
        s[z] = ((m_pwm % (1 << PW)) >= (1 << (PW - 1)));
`endif
    end
    return s;
  endfunction

  function automatic logic [NZ-1:0] exp_led();
    logic [NZ-1:0] l;
    for (int z = 0; z < NZ; z++) l[z] = m_manual[z];
    return l;
  endfunction

  task automatic step(input logic r, input logic [NZ-1:0] ir, input logic [NZ-1:0] bt, input logic dt);
    rst = r; infravermelho = ir; push_button = bt; desliga_tudo = dt;
    @(posedge clk);
    model_edge(r, ir, bt, dt);
    #1;
    check("model{saida,led}", 32'({saida, led}), 32'({exp_saida(), exp_led()}));
  endtask

  task automatic do_reset();
    step(1'b0, '0, '0, 1'b0);
    check("reset_outputs", 32'({saida, led}), 32'd0);
  endtask

  task automatic press(input int z, input int n);
    logic [NZ-1:0] b;
    b = '0;
    b[z] = 1'b1;
    repeat (n) step(1'b1, '0, b, 1'b0);
    repeat (6) step(1'b1, '0, '0, 1'b0);
  endtask

  typedef struct {
    int   hold;
    logic exp_led;
    logic exp_saida;
  } vec_t;

  vec_t vt[8];

  initial begin
    int hi_cnt;
    int bt_left [NZ];
    int ir_left [NZ];
    logic [NZ-1:0] bt_lvl, ir_lvl;

    vt[0] = '{hold: 3,  exp_led: 1'b0, exp_saida: 1'b0};
    vt[1] = '{hold: 25, exp_led: 1'b1, exp_saida: 1'b0};
    vt[2] = '{hold: 10, exp_led: 1'b1, exp_saida: 1'b1};
    vt[3] = '{hold: 10, exp_led: 1'b1, exp_saida: 1'b0};
    vt[4] = '{hold: 4,  exp_led: 1'b1, exp_saida: 1'b1};
    vt[5] = '{hold: 19, exp_led: 1'b1, exp_saida: 1'b0};
    vt[6] = '{hold: 20, exp_led: 1'b0, exp_saida: 1'b0};
    vt[7] = '{hold: 5,  exp_led: 1'b0, exp_saida: 1'b0};

    // Button press table on zone 0
    do_reset();
    for (int i = 0; i < 8; i++) begin
      press(0, vt[i].hold);
      check($sformatf("table%0d_led0", i), 32'(led[0]), 32'(vt[i].exp_led));
      check($sformatf("table%0d_saida0", i), 32'(saida[0]), 32'(vt[i].exp_saida));
      check($sformatf("table%0d_zone1", i), 32'({saida[1], led[1]}), 32'd0);
    end

    // Bounce on zone 1: two 3-cycle bursts
    do_reset();
    repeat (3) step(1'b1, '0, 2'b10, 1'b0);
    step(1'b1, '0, '0, 1'b0);
    repeat (3) step(1'b1, '0, 2'b10, 1'b0);
    repeat (6) step(1'b1, '0, '0, 1'b0);
    check("bounce_zone1", 32'({saida[1], led[1]}), 32'd0);

    // Presence pulse: on three edges later, off exactly T cycles later
    do_reset();
    hi_cnt = 0;
    for (int k = 0; k < 60; k++) begin
      step(1'b1, (k == 0) ? 2'b01 : 2'b00, '0, 1'b0);
      if (saida[0]) hi_cnt++;
      if (k == 1)  check("pres_before_rise", 32'(saida[0]), 32'd0);
      if (k == 2)  check("pres_rise", 32'(saida[0]), 32'd1);
`ifndef AUTO_DIM_EN
      if (k == 51) check("pres_last_on", 32'(saida[0]), 32'd1);
`endif
      if (k == 52) check("pres_fall", 32'(saida[0]), 32'd0);
    end
`ifndef AUTO_DIM_EN
    check("pres_on_cycles", 32'(hi_cnt), 32'(T));
`endif
    check("pres_zone1_dark", 32'({saida[1], led[1]}), 32'd0);

    // Long press released so that longo lands in the timeout cycle
    do_reset();
    for (int k = 0; k < 56; k++) begin
      step(1'b1, (k == 0) ? 2'b01 : 2'b00, (k >= 24 && k <= 48) ? 2'b01 : 2'b00, 1'b0);
      if (k == 51) check("coinc_led_before", 32'(led[0]), 32'd0);
      if (k == 52) check("coinc_after", 32'({saida[0], led[0]}), 32'b10 >> 1);
    end
    check("coinc_final", 32'({saida[0], led[0]}), 32'd1);

    // Global all-off with zone 0 in LIG_MAN and zone 1 in LIG_AUT
    do_reset();
    press(0, 25);
    press(0, 10);
    step(1'b1, 2'b10, '0, 1'b0);
    repeat (4) step(1'b1, '0, '0, 1'b0);
    check("alloff_pre", 32'({saida, led}), 32'b1101);
    step(1'b1, '0, '0, 1'b1);
    check("alloff_post", 32'({saida, led}), 32'd0);
    step(1'b1, 2'b10, '0, 1'b0);
    repeat (2) step(1'b1, '0, '0, 1'b0);
    check("alloff_relight", 32'({saida, led}), 32'b1000);

    // Reset in the middle of a 15-cycle hold from DESL_MAN
    do_reset();
    press(0, 25);
    check("midrst_manual", 32'(led[0]), 32'd1);
    for (int k = 0; k < 15; k++) begin
      step((k == 7) ? 1'b0 : 1'b1, '0, 2'b01, 1'b0);
      if (k == 7) check("midrst_outputs", 32'({saida, led}), 32'd0);
    end
    repeat (8) step(1'b1, '0, '0, 1'b0);
    check("midrst_after_release", 32'({saida, led}), 32'd0);

    // Randomized traffic; button lows last at least 2 cycles
    do_reset();
    bt_lvl = '0; ir_lvl = '0;
    for (int z = 0; z < NZ; z++) begin
      bt_left[z] = $urandom_range(1, 20);
      ir_left[z] = $urandom_range(1, 80);
    end
    for (int c = 0; c < 4000; c++) begin
      for (int z = 0; z < NZ; z++) begin
        bt_left[z]--;
        if (bt_left[z] <= 0) begin
          bt_lvl[z]  = !bt_lvl[z];
          bt_left[z] = bt_lvl[z] ? $urandom_range(1, 30) : $urandom_range(2, 20);
        end
        ir_left[z]--;
        if (ir_left[z] <= 0) begin
          ir_lvl[z]  = !ir_lvl[z];
          ir_left[z] = ir_lvl[z] ? $urandom_range(1, 5) : $urandom_range(20, 120);
        end
      end
      step(($urandom_range(0, 999) == 0) ? 1'b0 : 1'b1, ir_lvl, bt_lvl,
           ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
